// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue/completion controller:
// op encodings, default widths and small op-decode helpers.
package div_ctrl_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int DIV_LAT_DEF   = 32;
   localparam int TAG_W_DEF     = 5;
   localparam int OUT_DEPTH_DEF = 4;
   localparam int OP_W          = 2;

   typedef enum logic [OP_W-1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   // Bit 0 clear means a signed op, bit 1 set means the remainder is wanted.
   function automatic logic op_signed(input div_op_e op);
      return !op[0];
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_ctrl_fifo.sv
// Generic synchronous FIFO with first-word fall-through read from registered
// storage; pointers wrap modulo DEPTH so any depth >= 1 works.
module div_ctrl_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Storage is not reset; empty gates anything read from it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/div_ctrl.sv
// Issue/completion controller around a non-stallable pipelined unsigned divider.
// Optional macro DIV_CTRL_FLUSH_EN adds a flush input that drops all in-flight work.
module div_ctrl #(
   parameter int XLEN      = div_ctrl_pkg::XLEN_DEF,
   parameter int DIV_LAT   = div_ctrl_pkg::DIV_LAT_DEF,
   parameter int TAG_W     = div_ctrl_pkg::TAG_W_DEF,
   parameter int OUT_DEPTH = div_ctrl_pkg::OUT_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
`ifdef DIV_CTRL_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             div_vld,
   output logic [XLEN-1:0]  div_dividend,
   output logic [XLEN-1:0]  div_divisor,
   input  logic             div_res_vld,
   input  logic [XLEN-1:0]  div_quot,
   input  logic [XLEN-1:0]  div_rem,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag
);

   import div_ctrl_pkg::*;

   // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. Neither valid waits on ready.

   localparam int CW = $clog2(OUT_DEPTH+1);
   localparam int QW = $clog2(DIV_LAT+2);
   localparam int FW = TAG_W + XLEN;
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef struct packed {
      logic             valid;
      div_op_e          op;
      logic [TAG_W-1:0] tag;
      logic             neg_q;
      logic             neg_r;
      logic             dz;
      logic             ovf;
      logic [XLEN-1:0]  a;
   } meta_t;

   logic             flush_i;
   logic             accept;
   logic             pop;
   logic [CW-1:0]    cnt;
   logic [QW-1:0]    quiet_cnt;
   div_op_e          op_in;
   logic             in_signed;
   logic             sa;
   logic             sb;
   meta_t            new_meta;
   meta_t            iss_meta;
   meta_t            pipe [DIV_LAT];
   meta_t            head;
   logic             fx_valid;
   logic [TAG_W-1:0] fx_tag;
   logic [XLEN-1:0]  fx_data;
   logic [XLEN-1:0]  fix_data;
   logic             fifo_clr;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_cnt;
   logic [FW-1:0]    fifo_dout;

`ifdef DIV_CTRL_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   assign op_in     = div_op_e'(in_op);
   assign in_signed = op_signed(op_in);
   assign sa        = in_signed && in_a[XLEN-1];
   assign sb        = in_signed && in_b[XLEN-1];
   assign in_ready  = !rst && !flush_i && (cnt < CW'(OUT_DEPTH));
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = pipe[DIV_LAT-1];

   always_comb begin
      new_meta       = '0;
      new_meta.valid = 1'b1;
      new_meta.op    = op_in;
      new_meta.tag   = in_tag;
      new_meta.neg_q = sa ^ sb;
      new_meta.neg_r = sa;
      new_meta.dz    = (in_b == '0);
      new_meta.ovf   = in_signed && (in_a == MIN_INT) && (in_b == '1);
      new_meta.a     = in_a;
   end

   // Issue register; negating 0x80000000 yields itself, which the unsigned divider wants.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_vld      <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         div_vld <= accept;
         if (accept) begin
            div_dividend <= sa ? -in_a : in_a;
            div_divisor  <= sb ? -in_b : in_b;
         end
      end
   end

   // iss_meta travels with div_vld; pipe[] then mirrors the divider's DIV_LAT stages.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         iss_meta <= '0;
         for (int i = 0; i < DIV_LAT; i++) pipe[i] <= '0;
      end else begin
         iss_meta <= accept ? new_meta : '0;
         pipe[0]  <= iss_meta;
         for (int i = 1; i < DIV_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      fix_data = div_quot;
      if (head.dz)
         fix_data = op_is_rem(head.op) ? head.a : '1;
      else if (head.ovf)
         fix_data = op_is_rem(head.op) ? '0 : MIN_INT;
      else if (op_is_rem(head.op))
         fix_data = head.neg_r ? -div_rem : div_rem;
      else
         fix_data = head.neg_q ? -div_quot : div_quot;
   end

   // Results whose metadata was cleared by reset or flush are dropped here.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         fx_valid <= 1'b0;
         fx_tag   <= '0;
         fx_data  <= '0;
      end else begin
         fx_valid <= div_res_vld && head.valid;
         if (div_res_vld && head.valid) begin
            fx_tag  <= head.tag;
            fx_data <= fix_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i)          cnt <= '0;
      else if (accept && !pop)     cnt <= cnt + 1'b1;
      else if (pop && !accept)     cnt <= cnt - 1'b1;
   end

   // Window after reset/flush in which stale divider results may still emerge.
   always_ff @(posedge clk) begin
      if (rst || flush_i)          quiet_cnt <= QW'(DIV_LAT+1);
      else if (quiet_cnt != '0)    quiet_cnt <= quiet_cnt - 1'b1;
   end

   assign fifo_clr = rst || flush_i;

   div_ctrl_fifo #(
      .WIDTH(FW),
      .DEPTH(OUT_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (fifo_clr),
      .push     (fx_valid),
      .push_data({fx_tag, fx_data}),
      .pop      (pop),
      .pop_data (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   assign out_valid           = !fifo_empty;
   assign {out_tag, out_data} = out_valid ? fifo_dout : '0;

   assert property (@(posedge clk) disable iff (rst)
                    (div_res_vld && quiet_cnt == '0) |-> head.valid);
   assert property (@(posedge clk) disable iff (rst) fifo_cnt <= cnt);
   assert property (@(posedge clk) disable iff (rst) fifo_full |-> (cnt == CW'(OUT_DEPTH)));

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl with a behavioural pipelined divider and a
// scoreboard of expected {tag, result} pairs.
module tb_div_ctrl;

   import div_ctrl_pkg::*;

   localparam int XLEN      = 32;
   localparam int DIV_LAT   = 32;
   localparam int TAG_W     = 5;
   localparam int OUT_DEPTH = 4;
   localparam int W         = TAG_W + XLEN;
   localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             div_vld;
   logic [XLEN-1:0]  div_dividend;
   logic [XLEN-1:0]  div_divisor;
   logic             div_res_vld;
   logic [XLEN-1:0]  div_quot;
   logic [XLEN-1:0]  div_rem;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic [TAG_W-1:0] out_tag;

   logic [W-1:0]     exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               acc_cyc  = 0;
   logic             flush_done   = 1'b0;
   logic             flushed_seen = 1'b0;

   div_ctrl #(
      .XLEN(XLEN), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef DIV_CTRL_FLUSH_EN
      .flush       (flush),
`endif
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .div_vld     (div_vld),
      .div_dividend(div_dividend),
      .div_divisor (div_divisor),
      .div_res_vld (div_res_vld),
      .div_quot    (div_quot),
      .div_rem     (div_rem),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   // ---------------- divider model: DIV_LAT cycles, never stalls, never reset ----------------
   logic [DIV_LAT-1:0] dm_vld = '0;
   logic [XLEN-1:0]    dm_a [DIV_LAT];
   logic [XLEN-1:0]    dm_b [DIV_LAT];

   always @(posedge clk) begin
      dm_vld  <= {dm_vld[DIV_LAT-2:0], div_vld};
      dm_a[0] <= div_dividend;
      dm_b[0] <= div_divisor;
      for (int i = 1; i < DIV_LAT; i++) begin
         dm_a[i] <= dm_a[i-1];
         dm_b[i] <= dm_b[i-1];
      end
   end

   assign div_res_vld = dm_vld[DIV_LAT-1];
   assign div_quot = (dm_b[DIV_LAT-1] == '0) ? '1 : dm_a[DIV_LAT-1] / dm_b[DIV_LAT-1];
   assign div_rem  = (dm_b[DIV_LAT-1] == '0) ? dm_a[DIV_LAT-1] : dm_a[DIV_LAT-1] % dm_b[DIV_LAT-1];

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (op)
         2'b00: begin
            if (b == '0) return '1;
            if (a == MIN_INT && b == '1) return MIN_INT;
            return XLEN'(sa / sb);
         end
         2'b01: return (b == '0) ? '1 : a / b;
         2'b10: begin
            if (b == '0) return a;
            if (a == MIN_INT && b == '1) return '0;
            return XLEN'(sa % sb);
         end
         default: return (b == '0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return MIN_INT;
         2: return '1;
         3: return XLEN'($urandom_range(1, 20));
         4: return -XLEN'($urandom_range(1, 20));
         default: return XLEN'($urandom());
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (flush_done && out_tag >= TAG_W'(24) && out_tag <= TAG_W'(27)) flushed_seen = 1'b1;
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("out_tag", out_tag, e[W-1:XLEN]);
            check("out_data", out_data, e[XLEN-1:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("accept", in_ready, 1'b1);
      @(posedge clk);
      exp_q.push_back({tag, ref_result(op, a, b)});
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int t0;
      int t_first;
      int n;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_div_vld", div_vld, 1'b0);
      check("post_rst_dividend", div_dividend, 0);
      check("post_rst_divisor", div_divisor, 0);
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_out_data", out_data, 0);
      check("post_rst_out_tag", out_tag, 0);
      @(posedge clk);
      #1;

      // Signed sign fix-up and first-result latency.
      send(OP_DIV, -32'sd7, 32'd2, 5'd3);
      t0 = acc_cyc;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("latency", cyc - t0, DIV_LAT + 2);
      @(posedge clk);
      #1;
      send(OP_REM, -32'sd7, 32'd2, 5'd4);
      wait_drain();

      // Divide by zero.
      send(OP_DIVU, 32'h1234, 32'd0, 5'd5);
      send(OP_REMU, 32'h1234, 32'd0, 5'd6);
      send(OP_DIV,  32'h1234, 32'd0, 5'd7);
      send(OP_REM,  -32'sd5,  32'd0, 5'd8);
      wait_drain();

      // Signed overflow and the same operands unsigned.
      send(OP_DIV,  MIN_INT, 32'hFFFF_FFFF, 5'd9);
      send(OP_REM,  MIN_INT, 32'hFFFF_FFFF, 5'd10);
      send(OP_DIVU, MIN_INT, 32'hFFFF_FFFF, 5'd11);
      send(OP_REMU, MIN_INT, 32'hFFFF_FFFF, 5'd12);
      wait_drain();

      // 40 back-to-back random ops; the first OUT_DEPTH go in on consecutive edges.
      t_first = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == OUT_DEPTH) begin
            @(negedge clk);
            check("credit_stall", in_ready, 1'b0);
            @(posedge clk);
            #1;
         end
         send(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), TAG_W'(i));
         if (i == 0) t_first = acc_cyc;
         if (i == OUT_DEPTH - 1) check("b2b_accepts", acc_cyc - t_first, OUT_DEPTH - 1);
      end
      wait_drain();

      // Backpressure: credits cap outstanding work, nothing is lost.
      out_ready = 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
         send(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), TAG_W'(13 + i));
         if (i == 0) t_first = acc_cyc;
      end
      check("bp_b2b_accepts", acc_cyc - t_first, OUT_DEPTH - 1);
      @(negedge clk);
      check("bp_in_ready_early", in_ready, 1'b0);
      repeat (60) @(negedge clk);
      check("bp_in_ready_late", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_pending", exp_q.size(), OUT_DEPTH);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();

      // Reset with three ops in flight; their results must never surface.
      send(OP_DIV,  32'd100, 32'd3, 5'd17);
      send(OP_REMU, 32'd100, 32'd3, 5'd18);
      send(OP_DIVU, 32'd100, 32'd3, 5'd19);
      idle(5);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_div_vld", div_vld, 1'b0);
      check("midrst_dividend", div_dividend, 0);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, 0);
      check("midrst_out_tag", out_tag, 0);
      check("midrst_in_ready_after", in_ready, 1'b1);
      @(posedge clk);
      #1;
      idle(50);
      send(OP_DIV, 32'd100, -32'sd7, 5'd2);
      wait_drain();

`ifdef DIV_CTRL_FLUSH_EN
      // Flush with two results parked in the FIFO and two in the divider.
      out_ready = 1'b0;
      send(OP_DIVU, 32'd50, 32'd5, 5'd24);
      send(OP_REMU, 32'd50, 32'd7, 5'd25);
      idle(40);
      send(OP_DIV,  -32'sd50, 32'd5, 5'd26);
      send(OP_REM,  -32'sd50, 32'd7, 5'd27);
      idle(3);
      flush      = 1'b1;
      flush_done = 1'b1;
      exp_q.delete();
      in_valid = 1'b1;
      in_op    = OP_DIVU;
      in_a     = 32'd9;
      in_b     = 32'd3;
      in_tag   = 5'd28;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready_after", in_ready, 1'b1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      idle(50);
      check("flushed_tag_seen", flushed_seen, 1'b0);
      for (int i = 0; i < OUT_DEPTH; i++) begin
         send(OP_DIV, XLEN'(i * 11), 32'd3, TAG_W'(1 + i));
         if (i == 0) t_first = acc_cyc;
      end
      check("flush_credits_reset", acc_cyc - t_first, OUT_DEPTH - 1);
      wait_drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
